// File: rtl/axi_lite_rd_arbiter.sv
// ---------------------------------------------------------------------------
// axi_lite_rd_arbiter
//
// Shares one read-only AXI-lite slave (AR/R channels) between two masters:
//   M0 = IFU instruction fetch, M1 = LSU load.
// Only one transaction is in flight at a time. The winning master's address
// is registered and presented to the slave. The single R beat is then routed
// back to the master that owns the transaction.
//
// Build option:
//   ARB_RR_EN  when defined, ties are resolved round-robin using a 1-bit
//              last-grant register. When undefined, fixed priority applies
//              and M1 (LSU) wins every tie.
//
// Ports:
//   clk, rst_n                     clock; synchronous active-low reset
//   i_m0_araddr / i_m0_arvalid     IFU read address and valid
//   o_m0_arready                   IFU address accepted
//   o_m0_rdata / o_m0_rresp        IFU read data and response
//   o_m0_rvalid / i_m0_rready      IFU read data valid and ready
//   i_m1_* / o_m1_*                same set, for the LSU
//   o_s_araddr / o_s_arvalid       registered slave address and valid
//   i_s_arready                    slave address ready
//   i_s_rdata / i_s_rresp          slave read data and response
//   i_s_rvalid / o_s_rready        slave read valid and ready
// ---------------------------------------------------------------------------
// state   | meaning
// --------+------------------------------------------------------------------
// ST_IDLE | no transaction; arbitrate between the masters and accept a winner
// ST_AR   | registered address presented to the slave, waiting for arready
// ST_R    | waiting for the slave's R beat, which is passed to the owner
// ---------------------------------------------------------------------------
module axi_lite_rd_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   // M0 (IFU)
   input  logic [ADDR_W-1:0] i_m0_araddr,
   input  logic              i_m0_arvalid,
   output logic              o_m0_arready,
   output logic [DATA_W-1:0] o_m0_rdata,
   output logic [1:0]        o_m0_rresp,
   output logic              o_m0_rvalid,
   input  logic              i_m0_rready,
   // M1 (LSU)
   input  logic [ADDR_W-1:0] i_m1_araddr,
   input  logic              i_m1_arvalid,
   output logic              o_m1_arready,
   output logic [DATA_W-1:0] o_m1_rdata,
   output logic [1:0]        o_m1_rresp,
   output logic              o_m1_rvalid,
   input  logic              i_m1_rready,
   // shared slave
   output logic [ADDR_W-1:0] o_s_araddr,
   output logic              o_s_arvalid,
   input  logic              i_s_arready,
   input  logic [DATA_W-1:0] i_s_rdata,
   input  logic [1:0]        i_s_rresp,
   input  logic              i_s_rvalid,
   output logic              o_s_rready
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_AR   = 2'd1,
      ST_R    = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_own;
   logic              w_own_nxt;
   logic [ADDR_W-1:0] r_s_araddr;
   logic [ADDR_W-1:0] w_s_araddr_nxt;
   logic              r_s_arvalid;
   logic              w_s_arvalid_nxt;

   logic              w_gnt0;
   logic              w_gnt1;
   logic              w_grant;
   logic              w_own_rready;
   logic              w_in_r;

   // -----------------------------------------------------------------------
   // Arbitration. The grant is only acted on in ST_IDLE. arready follows the
   // grant directly, so the winner's handshake completes in the same cycle.
   // -----------------------------------------------------------------------
`ifdef ARB_RR_EN
   logic r_last;

   // On a tie, the master that was not granted last wins.
   // A lone requester always wins.
   always_comb begin
      w_gnt1 = i_m1_arvalid & (~i_m0_arvalid | ~r_last);
      w_gnt0 = i_m0_arvalid & ~w_gnt1;
   end

   // last only moves on an accepted address in ST_IDLE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_last <= 1'b0;
      end else if ((r_state == ST_IDLE) && w_grant) begin
         r_last <= w_gnt1;
      end
   end
`else
   always_comb begin
      w_gnt1 = i_m1_arvalid;
      w_gnt0 = i_m0_arvalid & ~i_m1_arvalid;
   end
`endif

   assign w_grant      = w_gnt0 | w_gnt1;
   assign w_own_rready = r_own ? i_m1_rready : i_m0_rready;
   assign w_in_r       = (r_state == ST_R);

   // -----------------------------------------------------------------------
   // FSM state register
   // -----------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_own       <= 1'b0;
         r_s_araddr  <= '0;
         r_s_arvalid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_own       <= w_own_nxt;
         r_s_araddr  <= w_s_araddr_nxt;
         r_s_arvalid <= w_s_arvalid_nxt;
      end
   end

   // -----------------------------------------------------------------------
   // FSM next state
   // -----------------------------------------------------------------------
   always_comb begin
      w_state_nxt     = r_state;
      w_own_nxt       = r_own;
      w_s_araddr_nxt  = r_s_araddr;
      w_s_arvalid_nxt = r_s_arvalid;

      case (r_state)
         ST_IDLE: begin
            if (w_grant) begin
               w_own_nxt       = w_gnt1;
               w_s_araddr_nxt  = w_gnt1 ? i_m1_araddr : i_m0_araddr;
               w_s_arvalid_nxt = 1'b1;
               w_state_nxt     = ST_AR;
            end
         end
         ST_AR: begin
            // r_s_arvalid is 1 throughout this state, so only arready matters.
            if (i_s_arready) begin
               w_s_arvalid_nxt = 1'b0;
               w_state_nxt     = ST_R;
            end
         end
         ST_R: begin
            if (i_s_rvalid && w_own_rready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt     = ST_IDLE;
            w_s_arvalid_nxt = 1'b0;
         end
      endcase
   end

   // -----------------------------------------------------------------------
   // Outputs. The AR side to the slave is registered. The R path is a
   // combinational passthrough, gated by state and owner.
   // -----------------------------------------------------------------------
   always_comb begin
      o_m0_arready = 1'b0;
      o_m1_arready = 1'b0;
      o_m0_rvalid  = 1'b0;
      o_m1_rvalid  = 1'b0;
      o_m0_rdata   = '0;
      o_m1_rdata   = '0;
      o_m0_rresp   = 2'b00;
      o_m1_rresp   = 2'b00;
      o_s_rready   = 1'b0;

      if (r_state == ST_IDLE) begin
         o_m0_arready = w_gnt0;
         o_m1_arready = w_gnt1;
      end

      if (w_in_r) begin
         o_s_rready = w_own_rready;
         if (r_own) begin
            o_m1_rvalid = i_s_rvalid;
            o_m1_rdata  = i_s_rdata;
            o_m1_rresp  = i_s_rresp;
         end else begin
            o_m0_rvalid = i_s_rvalid;
            o_m0_rdata  = i_s_rdata;
            o_m0_rresp  = i_s_rresp;
         end
      end
   end

   assign o_s_araddr  = r_s_araddr;
   assign o_s_arvalid = r_s_arvalid;

endmodule
